// File: rtl/colisor_multi.sv
// Shot-resolution engine: scans one fleet's ship records for a live segment at (x, y),
// writes back the struck record and tracks per-fleet live ships for game over.
module colisor_multi #(
  parameter int COORD_W = 4,
  parameter int TAM     = 10,
  parameter int SEGS    = 5,
  parameter int NAVIOS  = 12,
  parameter int NUM_JOG = 2,
  localparam int ADDR_W = (NAVIOS > 1) ? $clog2(NAVIOS) : 1,
  localparam int JOG_W  = (NUM_JOG > 1) ? $clog2(NUM_JOG) : 1,
  localparam int CNT_W  = $clog2(SEGS + 1),
  localparam int REG_W  = 3 + SEGS * (2 * COORD_W + 1) + CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [JOG_W-1:0]   jogador,
  output logic               ready,
  output logic               done,
  output logic               hit,
  output logic               afundou,
  output logic [2:0]         tipo,
  output logic               invalido,
  output logic               fim_jogo,
  output logic [JOG_W-1:0]   perdedor,
  output logic [JOG_W-1:0]   mem_jog,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [REG_W-1:0]   mem_wdata,
  input  logic [REG_W-1:0]   mem_rdata
);

  localparam int SEG_W  = 2 * COORD_W + 1;
  localparam int LIVE_W = $clog2(NAVIOS + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NAVIOS - 1);

  typedef enum logic [2:0] {IDLE, LER, COMP, ESCREVE, FIM} state_t;

  state_t             state, next;
  logic [COORD_W-1:0] xr, yr;
  logic               bad_r, bad_in;
  logic               we_r, sink_r;
  logic               match;
  logic [CNT_W-1:0]   cnt;
  logic [REG_W-1:0]   new_rec;
  logic [LIVE_W-1:0]  live [NUM_JOG];

  assign ready  = (state == IDLE) && !fim_jogo;
  assign done   = (state == FIM);
  // Gating with reset keeps a write from landing on the edge that aborts ESCREVE.
  assign mem_we = we_r && !reset;
  assign bad_in = (int'(x) >= TAM) || (int'(y) >= TAM) || (int'(jogador) >= NUM_JOG);

  always_comb begin
    match   = 1'b0;
    new_rec = mem_rdata;
    for (int unsigned i = 0; i < SEGS; i++) begin
      if (!match && mem_rdata[3 + i*SEG_W + SEG_W - 1]
          && mem_rdata[3 + i*SEG_W +: COORD_W] == xr
          && mem_rdata[3 + i*SEG_W + COORD_W +: COORD_W] == yr) begin
        match = 1'b1;
        new_rec[3 + i*SEG_W + SEG_W - 1] = 1'b0;
      end
    end
    cnt = mem_rdata[REG_W-1 -: CNT_W];
    new_rec[REG_W-1 -: CNT_W] = (cnt == '0) ? cnt : cnt - CNT_W'(1);
  end

  // An out-of-range shot still spends one cycle in LER so done lands one edge later.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start && ready) next = LER;
      LER:     next = bad_r ? FIM : COMP;
      COMP:    if (match) next = ESCREVE;
               else if (mem_addr == LAST) next = FIM;
               else next = LER;
      ESCREVE: next = FIM;
      FIM:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      bad_r     <= 1'b0;
      we_r      <= 1'b0;
      sink_r    <= 1'b0;
      hit       <= 1'b0;
      afundou   <= 1'b0;
      tipo      <= '0;
      invalido  <= 1'b0;
      fim_jogo  <= 1'b0;
      perdedor  <= '0;
      mem_jog   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int unsigned j = 0; j < NUM_JOG; j++) live[j] <= LIVE_W'(NAVIOS);
    end else begin
      state <= next;
      we_r  <= 1'b0;
      case (state)
        IDLE: if (start && ready) begin
          xr       <= x;
          yr       <= y;
          hit      <= 1'b0;
          afundou  <= 1'b0;
          tipo     <= '0;
          invalido <= bad_in;
          bad_r    <= bad_in;
          if (!bad_in) begin
            mem_jog  <= jogador;
            mem_addr <= '0;
          end
        end
        COMP: begin
          if (match) begin
            we_r      <= 1'b1;
            mem_wdata <= new_rec;
            // Only a real 1->0 transition sinks; a saturated count never re-sinks.
            sink_r    <= (cnt == CNT_W'(1));
          end else if (mem_addr != LAST) begin
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        ESCREVE: begin
          hit     <= 1'b1;
          tipo    <= mem_wdata[2:0];
          afundou <= sink_r;
          if (sink_r) begin
            live[mem_jog] <= live[mem_jog] - LIVE_W'(1);
            if (live[mem_jog] == LIVE_W'(1)) begin
              fim_jogo <= 1'b1;
              perdedor <= mem_jog;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
